// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: decodes a command byte per CS frame and
// streams bytes into or out of a register bank with auto-increment.
module spi_reg_ctrl #(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    FETCH,
    CAPTURE,
    READ
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              cs_m;
  logic              cs_s;
  logic              cs_d;
  logic              armed;
  logic              block;
  logic              cs_end;

  assign cs_end = cs_s & ~cs_d;
  assign busy   = (state != IDLE);

  // block lifts on a CS rising edge, or once CS is seen high after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_m  <= 1'b1;
      cs_s  <= 1'b1;
      cs_d  <= 1'b1;
      armed <= 1'b0;
      block <= 1'b1;
    end else begin
      cs_m  <= spi_cs_n;
      cs_s  <= cs_m;
      cs_d  <= cs_s;
      armed <= 1'b1;
      if (cs_end || (armed && cs_m && cs_s))
        block <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      frame_done <= 1'b0;
      tx_byte    <= STATUS_BYTE;
    end else begin
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_byte <= STATUS_BYTE;
          if (rx_dv && !cs_s && !block) begin
            addr <= rx_byte[ADDR_W-1:0];
            if (rx_byte[7]) begin
              state   <= WRITE;
              tx_byte <= 8'h00;
            end else begin
              state    <= FETCH;
              reg_re   <= 1'b1;
              reg_addr <= rx_byte[ADDR_W-1:0];
            end
          end
        end
        WRITE: begin
          if (rx_dv) begin
            reg_we    <= 1'b1;
            reg_wdata <= rx_byte;
            reg_addr  <= addr;
            addr      <= addr + ADDR_W'(1);
          end
        end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          tx_byte <= reg_rdata;
          addr    <= addr + ADDR_W'(1);
          state   <= READ;
        end
        READ: begin
          // no new fetch may start once the frame is ending
          if (rx_dv && !cs_end) begin
            state    <= FETCH;
            reg_re   <= 1'b1;
            reg_addr <= addr;
          end
        end
        default: state <= IDLE;
      endcase
      if (cs_end && state != IDLE) begin
        state      <= IDLE;
        frame_done <= 1'b1;
        tx_byte    <= STATUS_BYTE;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomised frame-level bench for spi_reg_ctrl against a
// transaction model of the register bank and expected MISO stream.
module tb_spi_reg_ctrl;

  localparam int AW = 7;
  localparam int DEPTH = 128;
  localparam logic [7:0] STAT = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          spi_cs_n = 1'b1;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [7:0]    tx_byte;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata = 8'h00;
  logic          busy;
  logic          frame_done;

  spi_reg_ctrl #(.ADDR_W(AW), .STATUS_BYTE(STAT)) dut (
    .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n),
    .rx_dv(rx_dv), .rx_byte(rx_byte), .tx_byte(tx_byte),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seed(input int a);
    return 8'((a * 37 + 11) & 8'hFF);
  endfunction

  // register bank environment
  logic [7:0]       mem[DEPTH];
  logic [DEPTH-1:0] wr = '0;
  always @(posedge clk) begin
    if (reg_re)
      reg_rdata <= wr[reg_addr] ? mem[reg_addr] : seed(int'(reg_addr));
    if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
      wr[reg_addr]  <= 1'b1;
    end
  end

  // observed strobes
  logic [AW-1:0] we_a[$];
  logic [7:0]    we_d[$];
  logic [AW-1:0] re_q[$];
  int            fd_cnt = 0;
  int            overlap = 0;
  always @(negedge clk) begin
    if (reg_we) begin
      we_a.push_back(reg_addr);
      we_d.push_back(reg_wdata);
    end
    if (reg_re) re_q.push_back(reg_addr);
    if (frame_done) fd_cnt++;
    if (reg_we && reg_re) overlap++;
  end

  logic [7:0] ref_mem[DEPTH];
  logic [7:0] fb[$];
  logic [7:0] miso[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_dv = 1'b1;
    tick(1);
    rx_dv = 1'b0;
  endtask

  task automatic clear_obs();
    we_a.delete();
    we_d.delete();
    re_q.delete();
    miso.delete();
    fd_cnt = 0;
  endtask

  task automatic run_frame(input bit live);
    int n;
    int a;
    clear_obs();
    n = fb.size();
    spi_cs_n = 1'b0;
    tick(4);
    foreach (fb[i]) begin
      miso.push_back(tx_byte);
      send(fb[i]);
      tick(12);
    end
    spi_cs_n = 1'b1;
    tick(8);
    a = int'(fb[0][AW-1:0]);
    chk("frame_done", fd_cnt, live ? 1 : 0);
    chk("busy_end", busy, 0);
    chk("tx_end", tx_byte, STAT);
    chk("miso0", miso[0], STAT);
    if (!live) begin
      chk("blk_we", we_a.size(), 0);
      chk("blk_re", re_q.size(), 0);
    end else if (fb[0][7]) begin
      chk("we_cnt", we_a.size(), n - 1);
      chk("re_cnt", re_q.size(), 0);
      for (int i = 1; i < n; i++) begin
        if (i - 1 < we_a.size()) begin
          chk("we_addr", we_a[i-1], (a + i - 1) % DEPTH);
          chk("we_data", we_d[i-1], fb[i]);
        end
        ref_mem[(a + i - 1) % DEPTH] = fb[i];
        chk("miso_wr", miso[i], 8'h00);
      end
    end else begin
      chk("re_cnt", re_q.size(), n);
      chk("we_cnt", we_a.size(), 0);
      for (int k = 0; k < n; k++) begin
        if (k < re_q.size())
          chk("re_addr", re_q[k], (a + k) % DEPTH);
        if (k > 0)
          chk("miso_rd", miso[k], ref_mem[(a + k - 1) % DEPTH]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
    tick(3);
    chk("rst_tx", tx_byte, STAT);
    chk("rst_busy", busy, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_addr", reg_addr, 0);
    reset = 1'b0;
    tick(4);

    fb = '{8'h83, 8'h11, 8'h22, 8'h33};
    run_frame(1);
    fb = '{8'h90, 8'hC1, 8'hC2, 8'hC3};
    run_frame(1);
    fb = '{8'h10, 8'h00, 8'h00, 8'h00};
    run_frame(1);
    fb = '{8'hFF, 8'hAA, 8'hBB};
    run_frame(1);
    fb = '{8'h7E, 8'h00, 8'h00, 8'h00};
    run_frame(1);
    fb = '{8'h85};
    run_frame(1);
    fb = '{8'h33};
    run_frame(1);

    // CS abort right after a read command
    clear_obs();
    spi_cs_n = 1'b0;
    tick(4);
    send(8'h05);
    tick(1);
    spi_cs_n = 1'b1;
    tick(8);
    chk("abort_re_le1", re_q.size() <= 1, 1);
    chk("abort_busy", busy, 0);
    chk("abort_tx", tx_byte, STAT);
    chk("abort_fd", fd_cnt, 1);

    // data byte coincident with the CS rising edge
    clear_obs();
    spi_cs_n = 1'b0;
    tick(4);
    send(8'hA0);
    tick(12);
    spi_cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(8'h5A);
    tick(6);
    ref_mem[8'h20] = 8'h5A;
    chk("coin_we_cnt", we_a.size(), 1);
    if (we_a.size() > 0) begin
      chk("coin_addr", we_a[0], 8'h20);
      chk("coin_data", we_d[0], 8'h5A);
    end
    chk("coin_fd", fd_cnt, 1);
    chk("coin_busy", busy, 0);

    // reset in the middle of a write frame, CS held low
    spi_cs_n = 1'b0;
    tick(4);
    send(8'h90);
    tick(12);
    send(8'h77);
    tick(12);
    ref_mem[16] = 8'h77;
    reset = 1'b1;
    tick(2);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tx", tx_byte, STAT);
    reset = 1'b0;
    tick(2);
    clear_obs();
    send(8'h44);
    tick(12);
    send(8'h55);
    tick(12);
    chk("post_rst_we", we_a.size(), 0);
    chk("post_rst_re", re_q.size(), 0);
    chk("post_rst_busy", busy, 0);
    spi_cs_n = 1'b1;
    tick(8);
    chk("idle_cs_end_fd", fd_cnt, 0);
    fb = '{8'h91, 8'h66};
    run_frame(1);
    fb = '{8'h10, 8'h00, 8'h00};
    run_frame(1);

    for (int f = 0; f < 24; f++) begin
      int n;
      n = $urandom_range(1, 6);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
      run_frame(1);
    end

    chk("we_re_excl", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
